spi_master_fifo: RTL and testbench

Parametrised SPI master engine for the next-generation AHB SPI peripheral.
- Adds configurable word width, all four CPOL/CPHA modes, a programmable SCLK divider, multiple slave selects and a show-ahead RX FIFO with overflow flag.
- Sits under the AHB wrapper, which drives txdin/txgo from register writes and pops rxdout on data-register reads.

---
 rtl/spi_master_fifo.sv | 232 +++++++++++++++++++++++
 tb/tb_spi_master_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_fifo.sv
// SPI master engine (CPOL/CPHA modes, SCLK divider, multiple slave selects) with a show-ahead RX FIFO.
// Optional `define SPI_LSB_FIRST_EN adds the lsb_first input for LSB-first shifting.
//
// state | meaning
// IDLE  | txrdy=1, SCLK tracks cpol input, SSn all high, MOSI high
// SETUP | slave selected, one half-period before the first SCLK edge
// SHIFT | 2*DATA_W half-periods, SCLK toggles at the end of each
// HOLD  | one half-period with SCLK at idle level, then push rx word
module spi_master_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int NUM_SS = 2,
  parameter int DIV_W  = 8,
  localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] txdin,
  input  logic              txgo,
  output logic              txrdy,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clkdiv,
  input  logic [SS_W-1:0]   ss_sel,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic [DATA_W-1:0] rxdout,
  output logic              rxvalid,
  input  logic              rxrd,
  output logic [CNT_W-1:0]  rxcount,
  output logic              rxovf,
  input  logic              rxovf_clr,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic [NUM_SS-1:0] SSn
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int EW    = $clog2(2 * DATA_W) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    hp_cnt_q, hp_cnt_d;
  logic [EW-1:0]       edge_cnt_q, edge_cnt_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                lsb_cfg_q, lsb_cfg_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_SS-1:0]   ssn_q, ssn_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;

  logic                lsb_in;
  logic                hp_end;
  logic                leading;
  logic                push;
  logic                pop;
  logic                full;
  logic                wr_en;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  assign txrdy   = (state_q == IDLE);
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SSn     = ssn_q;
  assign hp_end  = (hp_cnt_q == '0);
  assign leading = ~edge_cnt_q[0];

  always_comb begin
    state_d    = state_q;
    hp_cnt_d   = hp_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_cfg_d  = lsb_cfg_q;
    div_d      = div_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ssn_d      = ssn_q;
    push       = 1'b0;

    if (state_q != IDLE) begin
      hp_cnt_d = hp_end ? div_q : hp_cnt_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        mosi_d = 1'b1;
        ssn_d  = '1;
        if (txgo) begin
          state_d    = SETUP;
          cpol_d     = cpol;
          cpha_d     = cpha;
          lsb_cfg_d  = lsb_in;
          div_d      = clkdiv;
          hp_cnt_d   = clkdiv;
          edge_cnt_d = '0;
          rx_sr_d    = '0;
          for (int i = 0; i < NUM_SS; i++) begin
            ssn_d[i] = (int'(ss_sel) != i);
          end
          // cpha=0 puts the first bit on MOSI before the first (sampling) edge
          if (!cpha) begin
            mosi_d  = lsb_in ? txdin[0] : txdin[DATA_W-1];
            tx_sr_d = lsb_in ? (txdin >> 1) : (txdin << 1);
          end else begin
            tx_sr_d = txdin;
          end
        end
      end
      SETUP: begin
        if (hp_end) state_d = SHIFT;
      end
      SHIFT: begin
        if (hp_end) begin
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + 1'b1;
          if (leading ^ cpha_q) begin
            rx_sr_d = lsb_cfg_q ? {MISO, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], MISO};
          end else begin
            mosi_d  = lsb_cfg_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
            tx_sr_d = lsb_cfg_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
          end
          if (edge_cnt_q == LAST_EDGE) begin
            state_d = HOLD;
            sclk_d  = cpol_q;
          end
        end
      end
      HOLD: begin
        sclk_d = cpol_q;
        if (hp_end) begin
          state_d = IDLE;
          ssn_d   = '1;
          mosi_d  = 1'b1;
          push    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle
  always_comb begin
    pop      = rxrd & (count_q != '0);
    full     = (count_q == CNT_W'(DEPTH));
    wr_en    = push & (~full | pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    ovf_d    = ovf_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = rx_sr_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (rxovf_clr) ovf_d = 1'b0;
    if (push & full & ~pop) ovf_d = 1'b1;
  end

  assign rxvalid = (count_q != '0);
  assign rxdout  = rxvalid ? mem_q[rd_ptr_q] : '0;
  assign rxcount = count_q;
  assign rxovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hp_cnt_q   <= '0;
      edge_cnt_q <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_cfg_q  <= 1'b0;
      div_q      <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b1;
      ssn_q      <= '1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_cnt_q   <= hp_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_cfg_q  <= lsb_cfg_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ssn_q      <= ssn_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: contents are only visible through count_q
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Self-checking bench for spi_master_fifo: a bit-level slave model plus a queue-based FIFO reference.
module tb_spi_master_fifo;
  localparam int W      = 8;
  localparam int DEPTH  = 4;
  localparam int NUM_SS = 2;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [W-1:0]      txdin = '0;
  logic              txgo = 1'b0;
  logic              txrdy;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic [DIV_W-1:0]  clkdiv = '0;
  logic              ss_sel = 1'b0;
  logic [W-1:0]      rxdout;
  logic              rxvalid;
  logic              rxrd = 1'b0;
  logic [2:0]        rxcount;
  logic              rxovf;
  logic              rxovf_clr = 1'b0;
  logic              MISO = 1'b1;
  logic              MOSI;
  logic              SCLK;
  logic [NUM_SS-1:0] SSn;

  spi_master_fifo #(.DATA_W(W), .DEPTH(DEPTH), .NUM_SS(NUM_SS), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .txdin(txdin), .txgo(txgo), .txrdy(txrdy),
    .cpol(cpol), .cpha(cpha), .clkdiv(clkdiv), .ss_sel(ss_sel),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(1'b0),
`endif
    .rxdout(rxdout), .rxvalid(rxvalid), .rxrd(rxrd), .rxcount(rxcount),
    .rxovf(rxovf), .rxovf_clr(rxovf_clr), .MISO(MISO), .MOSI(MOSI),
    .SCLK(SCLK), .SSn(SSn)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] model_q[$];
  bit model_ovf = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_fifo(input string tag);
    check_val({tag, "_cnt"},   32'(rxcount), 32'(model_q.size()));
    check_val({tag, "_valid"}, 32'(rxvalid), 32'(model_q.size() != 0));
    check_val({tag, "_data"},  32'(rxdout),  (model_q.size() != 0) ? 32'(model_q[0]) : 32'h0);
    check_val({tag, "_ovf"},   32'(rxovf),   32'(model_ovf));
  endtask

  task automatic pop_one(input string tag);
    check_fifo(tag);
    rxrd = 1'b1;
    @(negedge clk);
    rxrd = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic drain();
    while (model_q.size() != 0) pop_one("drain");
  endtask

  // One transfer; slave returns sl. Optional extra txgo while busy, pop in the push cycle,
  // or a reset after rst_edges SCLK edges.
  task automatic xfer(input string tag, input logic [W-1:0] tx, input logic [W-1:0] sl,
                      input logic pol, input logic pha, input logic [DIV_W-1:0] div,
                      input logic ss, input bit extra_go, input bit pop_end, input int rst_edges);
    int cyc, edges, bad_ss, bad_t, sb, lat, k;
    bit done, lead, popped;
    logic prev;
    logic [W-1:0] cap;
    logic [NUM_SS-1:0] exp_ssn;
    cpol = pol; cpha = pha; clkdiv = div; ss_sel = ss;
    @(negedge clk);
    @(negedge clk);
    check_val({tag, "_sclk_idle"}, 32'(SCLK), 32'(pol));
    prev = SCLK;
    txdin = tx; txgo = 1'b1;
    MISO = sl[W-1];
    sb = pha ? W - 1 : W - 2;
    k = int'(div) + 1;
    lat = 1 + k * (2 * W + 2);
    exp_ssn = '1;
    exp_ssn[ss] = 1'b0;
    cyc = 1; edges = 0; bad_ss = 0; bad_t = 0; done = 1'b0; popped = 1'b0; cap = '0;
    @(negedge clk);
    txgo = 1'b0;
    txdin = W'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
    clkdiv = DIV_W'($urandom); ss_sel = 1'($urandom);
    while (!done && cyc <= lat + 20) begin
      if (txrdy) begin
        done = 1'b1;
      end else begin
        if (SSn !== exp_ssn) bad_ss++;
        if (SCLK !== prev) begin
          edges++;
          lead = (SCLK !== pol);
          if (cyc != (edges + 1) * k + 1) bad_t++;
          if (pha ? !lead : lead) cap = {cap[W-2:0], MOSI};
          else if (sb >= 0) begin
            MISO = sl[sb];
            sb--;
          end
          prev = SCLK;
        end
        if (rst_edges > 0 && edges == rst_edges) begin
          rst = 1'b1; txgo = 1'b0;
          @(negedge clk);
          check_val({tag, "_rst_ssn"},   32'(SSn),     32'({NUM_SS{1'b1}}));
          check_val({tag, "_rst_sclk"},  32'(SCLK),    32'h0);
          check_val({tag, "_rst_mosi"},  32'(MOSI),    32'h1);
          check_val({tag, "_rst_txrdy"}, 32'(txrdy),   32'h1);
          check_val({tag, "_rst_cnt"},   32'(rxcount), 32'h0);
          rst = 1'b0;
          model_q.delete();
          model_ovf = 1'b0;
          return;
        end
        txgo = (extra_go && cyc == 3);
        if (extra_go && cyc == 3) txdin = ~tx;
        if (pop_end && cyc == lat - 1 && model_q.size() != 0) begin
          check_val({tag, "_pop_push_data"}, 32'(rxdout), 32'(model_q[0]));
          rxrd = 1'b1;
          popped = 1'b1;
        end else begin
          rxrd = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    rxrd = 1'b0; txgo = 1'b0;
    check_val({tag, "_done"},    32'(done),   32'h1);
    check_val({tag, "_latency"}, 32'(cyc),    32'(lat));
    check_val({tag, "_edges"},   32'(edges),  32'(2 * W));
    check_val({tag, "_edge_t"},  32'(bad_t),  32'h0);
    check_val({tag, "_mosi"},    32'(cap),    32'(tx));
    check_val({tag, "_ssn"},     32'(bad_ss), 32'h0);
    check_val({tag, "_ssn_end"}, 32'(SSn),    32'({NUM_SS{1'b1}}));
    check_val({tag, "_mosi_end"},32'(MOSI),   32'h1);
    if (popped) void'(model_q.pop_front());
    if (model_q.size() < DEPTH) model_q.push_back(sl);
    else model_ovf = 1'b1;
    check_fifo(tag);
  endtask

  initial begin
    @(negedge clk);
    check_val("rst_txrdy", 32'(txrdy),   32'h1);
    check_val("rst_sclk",  32'(SCLK),    32'h0);
    check_val("rst_mosi",  32'(MOSI),    32'h1);
    check_val("rst_ssn",   32'(SSn),     32'({NUM_SS{1'b1}}));
    check_fifo("rst");
    rst = 1'b0;
    @(negedge clk);

    xfer("t1", 8'hA5, 8'h3C, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 0);
    drain();
    pop_one("empty_pop");
    check_fifo("after_empty_pop");

    xfer("t2", 8'h5A, 8'hC3, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 0);
    drain();

    for (int i = 1; i <= 5; i++)
      xfer("t3", W'(i * 17), W'(i), 1'($urandom), 1'($urandom), DIV_W'($urandom_range(0, 2)),
           1'($urandom), 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) pop_one("t3_pop");
    check_fifo("t3_empty");
    rxovf_clr = 1'b1;
    @(negedge clk);
    rxovf_clr = 1'b0;
    model_ovf = 1'b0;
    check_fifo("t3_clr");

    for (int i = 0; i < 4; i++)
      xfer("t4_fill", W'($urandom), W'(8'h40 + i), 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 0);
    xfer("t4", 8'h99, 8'hE7, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 4; i++) pop_one("t4_pop");
    check_fifo("t4_empty");

    xfer("t5", 8'h81, 8'h18, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 5);
    @(negedge clk);
    check_fifo("t5_after");

    xfer("t6", 8'h6E, 8'h2D, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 0);
    drain();

    for (int n = 0; n < 14; n++) begin
      xfer("rnd", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
           DIV_W'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 0);
      for (int p = $urandom_range(0, 1); p > 0; p--) pop_one("rnd_pop");
      if ($urandom_range(0, 3) == 0) begin
        rxovf_clr = 1'b1;
        @(negedge clk);
        rxovf_clr = 1'b0;
        model_ovf = 1'b0;
        check_fifo("rnd_clr");
      end
    end
    drain();
    check_fifo("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
